apb_master_nslave: RTL and testbench
====================================

// Module: apb_master_nslave
// PURPOSE
//  Parametrised APB master (bridge) for the next-generation APB subsystem.
//  Accepts one command at a time on a valid/ready request port, decodes the
//  address to one of NUM_SLV slaves, runs the APB SETUP/ACCESS sequence with
//  PREADY wait states, and returns one response pulse with data and error.
//  Adds what the two-slave fixed version lacks: N slaves, PSTRB, wait-state
//  timeout, and decode-error reporting.
// PARAMETERS
//  ADDR_W   32  address width (PADDR, cmd_addr)
//  DATA_W   32  data width; must be a multiple of 8
//  NUM_SLV  4   number of slaves (1..16)
//  SEL_LSB  28  LSB of slave-index field; index = cmd_addr[SEL_LSB +: 4]
//  TIMEOUT  16  max ACCESS cycles without PREADY; 0 = timeout disabled
// PORTS
//  PCLK       in   1               clock
//  PRESETn    in   1               async reset, active low
//  cmd_valid  in   1               command request
//  cmd_ready  out  1               command accepted when valid&&ready
//  cmd_write  in   1               1=write, 0=read
//  cmd_addr   in   ADDR_W          target address
//  cmd_wdata  in   DATA_W          write data
//  cmd_strb   in   DATA_W/8        write byte strobes
//  rsp_valid  out  1               one-cycle response pulse (no backpressure)
//  rsp_rdata  out  DATA_W          read data; 0 for writes and errors
//  rsp_err    out  1               slave error, timeout or decode error
//  PADDR      out  ADDR_W          APB address
//  PSEL       out  NUM_SLV         one-hot slave select
//  PENABLE    out  1               APB enable
//  PWRITE     out  1               APB direction
//  PWDATA     out  DATA_W          APB write data
//  PSTRB      out  DATA_W/8        APB strobes (0 on reads)
//  PRDATA     in   NUM_SLV*DATA_W  per-slave read data, slave k at [k*DATA_W +: DATA_W]
//  PREADY     in   NUM_SLV         per-slave ready
//  PSLVERR    in   NUM_SLV         per-slave error
// BEHAVIOUR
//  - One clock PCLK; reset PRESETn is asynchronous, active low. On reset all
//    outputs are 0 (cmd_ready included), state = IDLE, timeout counter = 0.
//  - FSM states: IDLE, SETUP, ACCESS, RESP. cmd_ready=1 only in IDLE.
//  - IDLE: on valid&&ready, register addr/wdata/strb/write. If index<NUM_SLV
//    -> SETUP, else -> RESP with err=1 (decode error; no PSEL, no APB cycle).
//  - SETUP (1 cycle): PSEL[index]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB valid.
//    -> ACCESS.
//  - ACCESS: PENABLE=1; all APB outputs stable. Only PREADY/PSLVERR/PRDATA of
//    the selected slave are observed. PREADY=1 at edge: capture PSLVERR
//    into rsp_err and PRDATA slice into rsp_rdata (reads only) -> RESP.
//    Counter counts ACCESS cycles with PREADY=0; reaching TIMEOUT ->
//    RESP with err=1, rdata=0.
//  - RESP: rsp_valid=1 for exactly one cycle, PSEL=0, PENABLE=0 -> IDLE.
//  - Latency (acceptance edge = E0): zero-wait transfer gives rsp_valid
//    high in the cycle after E2 (3 cycles). Each wait state adds 1.
//    Decode error gives rsp_valid the cycle after E0.
//  - Back-to-back: the next command is accepted no earlier than the
//    cycle after RESP. Between transfers PSEL=PENABLE=0 for at least
//    1 cycle; PADDR/PWDATA hold their last values.
//  - PSTRB driven 0 for reads. rsp_rdata and rsp_err are meaningful only
//    while rsp_valid=1 and are cleared to 0 otherwise.
//  - PRESETn asserted mid-transfer: immediate abort, no rsp_valid emitted,
//    PSEL/PENABLE drop asynchronously.
// STRUCTURE
//  - apb_pkg: FSM state encoding (IDLE/SETUP/ACCESS/RESP), IDX_W=4 slave-
//    index width, error-source constants (SLV, TMO, DEC) for bench checks.
//  - Sub-module apb_addr_decoder: cmd_addr -> one-hot select + in_range flag
//    (combinational, parametrised by NUM_SLV/SEL_LSB).
//  - Top: FSM, request registers, timeout counter ($clog2(TIMEOUT+1) bits),
//    and response mux.
// TESTING
//  1 Write addr 0x1000_0010 data 0xA5A5_0001 strb 0xF, slave1 PREADY=1 ->
//    PSEL=4'b0010 in SETUP, rsp_valid 3 cycles after accept, err=0.
//  2 Read slave2 with 3 wait states, PRDATA=0xDEAD_BEEF -> rsp_valid
//    6 cycles after accept, rdata=0xDEAD_BEEF, APB outputs stable in ACCESS.
//  3 Read addr 0x5000_0000 (index 5 >= NUM_SLV) -> PSEL never set,
//    rsp_valid the cycle after accept, err=1, rdata=0.
//  4 Slave0 PREADY held low, TIMEOUT=16 -> abort after 16 ACCESS cycles,
//    err=1, rdata=0, PSEL/PENABLE drop in RESP.
//  5 Slave3 PREADY=1 with PSLVERR=1 on a write -> err=1; back-to-back
//    command held valid is accepted only when IDLE returns.
//  6 PRESETn low during ACCESS -> all outputs 0 asynchronously, no
//    rsp_valid; a new command completes normally after reset release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the N-slave APB master: FSM encoding, slave-index
// width and error-source tags used when reporting why a response carried err.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int IDX_W = 4;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SLV  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_DEC  = 2'd3;

endpackage

// File: rtl/apb_addr_decoder.sv
// Slave-index decoder: turns the 4-bit index field of the command address
// into a one-hot select plus a flag telling whether that slave exists.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int NUM_SLV = 4
) (
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic               in_range_o
);

    assign in_range_o = (32'(idx_i) < NUM_SLV);

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
            assign sel_o[gi] = (idx_i == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/apb_master_nslave.sv
// APB bridge: one valid/ready command at a time, address-decoded to one of
// NUM_SLV slaves, with PREADY wait states, timeout and decode-error reporting.
module apb_master_nslave
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_strb,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic                write_q, write_d;
    logic [NUM_SLV-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;

    logic [NUM_SLV-1:0]  dec_sel;
    logic                dec_in_range;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic [DATA_W-1:0]   slv_rdata [NUM_SLV];
    logic                tmo_hit;

    apb_addr_decoder #(
        .NUM_SLV (NUM_SLV)
    ) u_dec (
        .idx_i      (cmd_addr[SEL_LSB +: IDX_W]),
        .sel_o      (dec_sel),
        .in_range_o (dec_in_range)
    );

    // Only the selected slave's response lines may influence the transfer.
    assign sel_ready = |(PREADY & sel_q);
    assign sel_err   = |(PSLVERR & sel_q);

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_rmux
            assign slv_rdata[gi] = sel_q[gi] ? PRDATA[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            sel_rdata = sel_rdata | slv_rdata[k];
        end
    end

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        write_d = write_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    strb_d  = cmd_write ? cmd_strb : '0;
                    write_d = cmd_write;
                    sel_d   = dec_sel;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (dec_in_range) begin
                        state_d = SETUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // A completing PREADY wins over a timeout in the same cycle.
                if (sel_ready) begin
                    err_d   = sel_err;
                    rdata_d = (!write_q && !sel_err) ? sel_rdata : '0;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered ready keeps cmd_ready low while reset is asserted.
    assign ready_d = (state_d == IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = wdata_q;
    assign PSTRB     = strb_q;
    assign PSEL      = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
    assign PENABLE   = (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Randomized scoreboard bench for apb_master_nslave: directed scenarios plus a
// random stream, each response checked against a transaction-level model.
module tb_apb_master_nslave;
    import apb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NS   = 4;
    localparam int SLSB = 28;
    localparam int TMO  = 16;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_strb;
    logic            rsp_valid, rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   PADDR;
    logic [NS-1:0]   PSEL;
    logic            PENABLE, PWRITE;
    logic [DW-1:0]   PWDATA;
    logic [DW/8-1:0] PSTRB;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]   PREADY, PSLVERR;

    apb_master_nslave #(
        .ADDR_W (AW), .DATA_W (DW), .NUM_SLV (NS), .SEL_LSB (SLSB), .TIMEOUT (TMO)
    ) dut (
        .PCLK (PCLK), .PRESETn (PRESETn),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_strb (cmd_strb),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .PADDR (PADDR), .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE),
        .PWDATA (PWDATA), .PSTRB (PSTRB), .PRDATA (PRDATA), .PREADY (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            acc_cyc;
        logic [1:0]    src;
    } exp_t;
    exp_t sb[$];
    int   last_rsp_cyc = -10;

    // Context of the transfer currently owned by the slave model / monitor.
    int              cur_idx = 0;
    logic [AW-1:0]   cur_addr = '0;
    logic [DW-1:0]   cur_wdata = '0;
    logic [DW/8-1:0] cur_strb = '0;
    logic            cur_write = 1'b0;
    int              cur_waits = 0;
    logic            cur_slverr = 1'b0;
    logic [DW-1:0]   cur_prdata = '0;

    // Slave model: the addressed slave inserts cur_waits wait states; all
    // other slaves shout ready/error/garbage to expose wrong selection.
    initial begin
        int acc_n;
        acc_n   = 0;
        PREADY  = '1;
        PSLVERR = '1;
        PRDATA  = '0;
        forever begin
            @(negedge PCLK);
            acc_n = PENABLE ? acc_n + 1 : 0;
            for (int k = 0; k < NS; k++) begin
                if (k == cur_idx && PENABLE) begin
                    PREADY[k]              = (acc_n > cur_waits);
                    PSLVERR[k]             = cur_slverr;
                    PRDATA[k*DW +: DW]     = cur_prdata;
                end else begin
                    PREADY[k]              = 1'b1;
                    PSLVERR[k]             = 1'b1;
                    PRDATA[k*DW +: DW]     = $urandom;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every response and checks the APB bus.
    initial begin
        exp_t          e;
        logic [NS-1:0] es;
        logic [NS-1:0] prev_psel;
        int            lat;
        prev_psel = '0;
        forever begin
            @(negedge PCLK);
            if (PRESETn) begin
                if (!rsp_valid) begin
                    checks++;
                    if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_rsp_zero cyc=%0d rdata=%h err=%b required 0/0", cyc, rsp_rdata, rsp_err);
                    end
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp cyc=%0d rdata=%h err=%b with no command pending", cyc, rsp_rdata, rsp_err);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.acc_cyc + 1;
                    last_rsp_cyc = cyc;
                    checks += 3;
                    if (rsp_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL rsp_rdata cyc=%0d got %h required %h", cyc, rsp_rdata, e.rdata);
                    end
                    if (rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL rsp_err cyc=%0d got %b required %b (src %0d)", cyc, rsp_err, e.err, e.src);
                    end
                    if (lat != e.lat) begin
                        errors++;
                        $display("FAIL latency cyc=%0d got %0d required %0d", cyc, lat, e.lat);
                    end
                    $display("rsp cyc=%0d rdata=%h err=%b lat=%0d src=%0d", cyc, rsp_rdata, rsp_err, lat, e.src);
                end
                if (PSEL != '0 || PENABLE) begin
                    es = '0;
                    if (cur_idx < NS) es[cur_idx] = 1'b1;
                    checks++;
                    if (PSEL !== es || PADDR !== cur_addr || PWRITE !== cur_write ||
                        PWDATA !== cur_wdata || PSTRB !== (cur_write ? cur_strb : 4'h0)) begin
                        errors++;
                        $display("FAIL apb_bus cyc=%0d got sel=%b addr=%h wr=%b wd=%h strb=%h required sel=%b addr=%h wr=%b wd=%h strb=%h",
                                 cyc, PSEL, PADDR, PWRITE, PWDATA, PSTRB, es, cur_addr, cur_write, cur_wdata,
                                 cur_write ? cur_strb : 4'h0);
                    end
                    if (prev_psel == '0) begin
                        checks++;
                        if (PENABLE !== 1'b0) begin
                            errors++;
                            $display("FAIL setup_phase cyc=%0d PENABLE=%b required 0", cyc, PENABLE);
                        end
                    end
                end
                prev_psel = PSEL;
            end else begin
                prev_psel = '0;
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] st, input int waits, input logic serr,
                         input logic [DW-1:0] prd);
        exp_t e;
        int   idx;
        int   n;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = st;
        n = 0;
        forever begin
            @(negedge PCLK);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout cyc=%0d cmd_ready=%b required 1 within 200 cycles", cyc, cmd_ready);
                cmd_valid = 1'b0;
                return;
            end
        end
        idx = int'(addr[SLSB +: 4]);
        e.acc_cyc = cyc + 1;
        if (idx >= NS) begin
            e.src = ERR_DEC; e.err = 1'b1; e.rdata = '0; e.lat = 1;
        end else if (TMO > 0 && waits >= TMO) begin
            e.src = ERR_TMO; e.err = 1'b1; e.rdata = '0; e.lat = 2 + TMO;
        end else begin
            e.src   = serr ? ERR_SLV : ERR_NONE;
            e.err   = serr;
            e.rdata = (!wr && !serr) ? prd : '0;
            e.lat   = 3 + waits;
        end
        checks++;
        if (sb.size() != 0 || e.acc_cyc < last_rsp_cyc + 2) begin
            errors++;
            $display("FAIL accept_order cyc=%0d pending=%0d last_rsp=%0d required pending=0 and accept>=last_rsp+2",
                     cyc, sb.size(), last_rsp_cyc);
        end
        cur_idx = idx; cur_addr = addr; cur_wdata = wd; cur_strb = st; cur_write = wr;
        cur_waits = waits; cur_slverr = serr; cur_prdata = prd;
        sb.push_back(e);
        $display("cmd cyc=%0d wr=%b addr=%h wd=%h strb=%h waits=%0d serr=%b prd=%h", e.acc_cyc, wr, addr, wd, st, waits, serr, prd);
        @(posedge PCLK);
        #1;
    endtask

    task automatic drop(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cyc=%0d pending=%0d required 0", cyc, sb.size());
            sb.delete();
        end
    endtask

    function automatic logic any_out();
        return |{cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ridx;
        logic [31:0] raddr;
        int          r, w, n;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        #12;
        checks++;
        if (any_out() !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero outputs (ready=%b psel=%b) required all 0", cmd_ready, PSEL);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;

        // 1: zero-wait write to slave 1
        issue(1'b1, 32'h1000_0010, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h1234_5678);
        drop(1); drain();
        // 2: read slave 2 with 3 wait states
        issue(1'b0, 32'h2000_0004, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF);
        drop(1); drain();
        // 3: decode error
        issue(1'b0, 32'h5000_0000, 32'h0, 4'h0, 0, 1'b0, 32'hFFFF_FFFF);
        drop(1); drain();
        // 4: slave 0 never ready -> timeout
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1000, 1'b0, 32'hCAFE_F00D);
        drop(1); drain();
        // 5: slave error on write, then a command held valid back-to-back
        issue(1'b1, 32'h3000_0008, 32'h0BAD_0BAD, 4'h3, 1, 1'b1, 32'h0);
        issue(1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 1'b0, 32'h600D_600D);
        drop(1); drain();

        // 6: reset during ACCESS aborts with no response
        issue(1'b0, 32'h1000_0020, 32'h0, 4'h0, 1000, 1'b0, 32'h1111_2222);
        drop(0);
        n = 0;
        while (!PENABLE && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        @(negedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        checks++;
        if (any_out() !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got psel=%b penable=%b rsp_valid=%b required all outputs 0", PSEL, PENABLE, rsp_valid);
        end
        sb.delete();
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        issue(1'b0, 32'h1000_0030, 32'h0, 4'h0, 2, 1'b0, 32'h7777_AAAA);
        drop(1); drain();

        // random stream, including waits just below and at the timeout
        for (int t = 0; t < 40; t++) begin
            ridx  = 4'($urandom_range(0, 5));
            raddr = {ridx, 28'($urandom)};
            r = $urandom_range(0, 9);
            if (r < 7)       w = r % 4;
            else if (r == 7) w = TMO - 1;
            else if (r == 8) w = TMO;
            else             w = 0;
            issue(1'($urandom), raddr, $urandom, 4'($urandom), w, ($urandom_range(0, 3) == 0), $urandom);
            n = $urandom_range(0, 2);
            if (n > 0) drop(n);
        end
        drop(1);
        drain();
        repeat (3) @(negedge PCLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
